// File: rtl/seq_frame_pkg.sv
// Shared types and constants for the serial frame transmitter and its receive-side detectors.
package seq_frame_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;

    localparam int SYNC_W_DEF = 6;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 6'b101010;

    // Width of one counter that can count any of the per-state phase lengths.
    function automatic int cnt_w(input int sync_w, input int data_w, input int gap_cyc);
        int m;
        m = (sync_w > data_w) ? sync_w : data_w;
        if (gap_cyc > m) m = gap_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_frame_piso.sv
// Loadable parallel-in/serial-out shift register; MSB leaves first, zeros shift in.
module seq_frame_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst)       sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr << 1;
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync preamble, MSB-first payload, idle gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int                SYNC_W   = 6,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                DATA_W   = 8,
    parameter int                GAP_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_bit,
    output logic              tx_bit_en,
    output logic              frame_start,
    output logic              tx_last
);

    localparam int CW = cnt_w(SYNC_W, DATA_W, GAP_CYC);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_END = CW'(DATA_W - 1);
    localparam logic [CW-1:0] DATA_PEN = CW'(DATA_W - 2);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [SYNC_W-1:0] sync_sr;
    logic              piso_msb;
    logic              load;
    logic              shift;

    assign tx_ready = (state == IDLE);
    assign load     = tx_ready && tx_valid;
    // The register is shifted on the edge that puts its MSB on the line.
    assign shift    = (state == SYNC && cnt == SYNC_END) ||
                      (state == DATA && cnt != DATA_END);

    seq_frame_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (tx_data),
        .msb   (piso_msb)
    );

`ifdef SEQ_FRAME_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (!rst)      par <= 1'b0;
        else if (load) par <= ^tx_data;
    end
`endif

    // state/cnt name the bit currently on the line; outputs are loaded for the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sync_sr     <= '0;
            tx_bit      <= 1'b0;
            tx_bit_en   <= 1'b0;
            frame_start <= 1'b0;
            tx_last     <= 1'b0;
        end else begin
            tx_bit      <= 1'b0;
            tx_bit_en   <= 1'b0;
            frame_start <= 1'b0;
            tx_last     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state       <= SYNC;
                        cnt         <= '0;
                        sync_sr     <= SYNC_PAT << 1;
                        tx_bit      <= SYNC_PAT[SYNC_W-1];
                        tx_bit_en   <= 1'b1;
                        frame_start <= 1'b1;
                    end
                end
                SYNC: begin
                    tx_bit_en <= 1'b1;
                    if (cnt == SYNC_END) begin
                        state  <= DATA;
                        cnt    <= '0;
                        tx_bit <= piso_msb;
`ifndef SEQ_FRAME_TX_PARITY_EN
                        tx_last <= (DATA_W == 1);
`endif
                    end else begin
                        cnt     <= cnt + 1'b1;
                        tx_bit  <= sync_sr[SYNC_W-1];
                        sync_sr <= sync_sr << 1;
                    end
                end
                DATA: begin
                    if (cnt == DATA_END) begin
                        cnt <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state     <= PAR;
                        tx_bit    <= par;
                        tx_bit_en <= 1'b1;
                        tx_last   <= 1'b1;
`else
                        state <= (GAP_CYC == 0) ? IDLE : GAP;
`endif
                    end else begin
                        cnt       <= cnt + 1'b1;
                        tx_bit    <= piso_msb;
                        tx_bit_en <= 1'b1;
`ifndef SEQ_FRAME_TX_PARITY_EN
                        tx_last   <= (DATA_W >= 2) && (cnt == DATA_PEN);
`endif
                    end
                end
`ifdef SEQ_FRAME_TX_PARITY_EN
                PAR: begin
                    cnt   <= '0;
                    state <= (GAP_CYC == 0) ? IDLE : GAP;
                end
`endif
                GAP: begin
                    if (cnt == GAP_END) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: table-driven frame, corner sequences, random traffic vs a queue model.
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int PB = 1;
    localparam logic [14:0] A5_STREAM = 15'b101010101001010;
    localparam logic [14:0] C3_STREAM = 15'b101010001111000;
`else
    localparam int PB = 0;
    localparam logic [13:0] A5_STREAM = 14'b10101010100101;
    localparam logic [13:0] C3_STREAM = 14'b10101000111100;
`endif
    localparam int FL  = 14 + PB;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_bit, tx_bit_en, frame_start, tx_last;

    logic       v2;
    logic [4:0] d2;
    logic       ready2, bit2, en2, fs2, last2;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_frame_tx dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_bit(tx_bit), .tx_bit_en(tx_bit_en), .frame_start(frame_start), .tx_last(tx_last)
    );

    seq_frame_tx #(.SYNC_W(4), .SYNC_PAT(4'b1100), .DATA_W(5), .GAP_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(v2), .tx_ready(ready2), .tx_data(d2),
        .tx_bit(bit2), .tx_bit_en(en2), .frame_start(fs2), .tx_last(last2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted word expands into a queue of per-cycle {bit,en,start,last}.
    logic [3:0] q[$];
    logic [3:0] m_exp = 4'b0;
    logic       m_rdy = 1'b1;

    function automatic void push_frame(input logic [7:0] d);
        logic [5:0] sp;
        logic [7:0] dd;
        sp = 6'b101010;
        dd = d;
        for (int i = 0; i < 6; i++) begin
            q.push_back({sp[5], 1'b1, (i == 0), 1'b0});
            sp = sp << 1;
        end
        for (int i = 0; i < 8; i++) begin
            q.push_back({dd[7], 1'b1, 1'b0, (PB == 0 && i == 7)});
            dd = dd << 1;
        end
        if (PB == 1) q.push_back({^d, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < GAP; i++) q.push_back(4'b0000);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_exp <= 4'b0;
            m_rdy <= 1'b1;
        end else begin
            if (m_rdy && tx_valid) push_frame(tx_data);
            if (q.size() > 0) begin
                m_exp <= q.pop_front();
                m_rdy <= 1'b0;
            end else begin
                m_exp <= 4'b0;
                m_rdy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("model", {27'b0, tx_ready, tx_bit, tx_bit_en, frame_start, tx_last}, {27'b0, m_rdy, m_exp});
    end

    task automatic wait_ready();
        for (int c = 0; c < 50; c++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        chk("wait_ready", {31'b0, tx_ready}, 32'd1);
    endtask

    // Transfer one word from idle and collect the enabled bits MSB-first until tx_bit_en drops.
    task automatic run_frame(input logic [7:0] d, output logic [15:0] bits, output int n, output int last_at);
        bits = '0; n = 0; last_at = -1;
        tx_valid = 1'b1; tx_data = d;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (n > 0 && !tx_bit_en) break;
            if (tx_bit_en) begin
                bits = {bits[14:0], tx_bit};
                if (tx_last) last_at = n;
                n++;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp;   // {ready, bit, en, start, last}
    } vec_t;

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [FL-1:0] stream;
        logic [15:0] bits;
        logic [7:0]  p1, p2;
        logic        bq[$];
        int          n, last_at, t_last, t_fs2;
        logic        got_last;

        stream = A5_STREAM;
        for (int i = 0; i < FL + 2; i++) begin
            v.valid = (i == 0);
            v.data  = (i == 0) ? 8'hA5 : 8'($urandom);
            if (i < FL) begin
                v.exp  = {1'b0, stream[FL-1], 1'b1, (i == 0), (i == FL - 1)};
                stream = stream << 1;
            end else begin
                v.exp = (i == FL) ? 5'b00000 : 5'b10000;
            end
            tbl.push_back(v);
        end

        // Reset held with valid high: nothing leaves the block.
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A; v2 = 1'b0; d2 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_en", {31'b0, tx_bit_en}, 32'd0);
            chk("rst_start", {31'b0, frame_start}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, tx_ready}, 32'd1);

        // Single A5 frame, cycle by cycle.
        wait_ready();
        for (int i = 0; i < tbl.size(); i++) begin
            tx_valid = tbl[i].valid; tx_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("a5_row%0d", i), {27'b0, tx_ready, tx_bit, tx_bit_en, frame_start, tx_last},
                {27'b0, tbl[i].exp});
        end
        tx_valid = 1'b0;

        // Back-to-back with valid held; data changes mid-frame.
        wait_ready();
        tx_valid = 1'b1; tx_data = 8'hFF; t_last = -1; t_fs2 = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 4) tx_data = 8'h00;
            if (tx_bit_en) bq.push_back(tx_bit);
            if (tx_last && t_last < 0) t_last = c;
            if (frame_start && t_last >= 0 && t_fs2 < 0) t_fs2 = c;
            if (bq.size() == 2 * FL) break;
        end
        tx_valid = 1'b0;
        chk("b2b_bits", bq.size(), 2 * FL);
        chk("b2b_gap", t_fs2 - t_last, GAP + 2);
        p1 = '0; p2 = '0;
        if (bq.size() == 2 * FL) begin
            for (int k = 0; k < 8; k++) begin
                p1 = {p1[6:0], bq[6 + k]};
                p2 = {p2[6:0], bq[FL + 6 + k]};
            end
        end
        chk("b2b_payload1", {24'b0, p1}, 32'hFF);
        chk("b2b_payload2", {24'b0, p2}, 32'h00);

        // Reset during data bit 3, then a full clean frame.
        wait_ready();
        tx_valid = 1'b1; tx_data = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);
        chk("abort_setup", {31'b0, tx_bit_en}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {28'b0, tx_bit_en, tx_bit, frame_start, tx_last}, 32'd0);
        chk("abort_ready", {31'b0, tx_ready}, 32'd1);
        rst = 1'b1;
        run_frame(8'h3C, bits, n, last_at);
        chk("after_abort_len", n, FL);
        chk("after_abort_bits", {16'b0, bits}, {16'b0, 16'(C3_STREAM)});
        chk("after_abort_last", last_at, FL - 1);
        wait_ready();

`ifdef SEQ_FRAME_TX_PARITY_EN
        run_frame(8'h07, bits, n, last_at);
        chk("par07_len", n, 15);
        chk("par07_bit", {31'b0, bits[0]}, 32'd1);
        chk("par07_last", last_at, 14);
        wait_ready();
        run_frame(8'h03, bits, n, last_at);
        chk("par03_bit", {31'b0, bits[0]}, 32'd0);
        wait_ready();
`endif

        // Overridden geometry, zero gap.
        v2 = 1'b1; d2 = 5'b10011;
        @(negedge clk);
        v2 = 1'b0;
        bits = '0; n = 0; got_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (got_last) begin
                chk("ovr_ready_after_last", {31'b0, ready2}, 32'd1);
                break;
            end
            if (en2) begin
                bits = {bits[14:0], bit2};
                n++;
            end
            if (last2) got_last = 1'b1;
            @(negedge clk);
        end
        chk("ovr_last_seen", {31'b0, got_last}, 32'd1);
        chk("ovr_len", n, 9 + PB);
        chk("ovr_bits", {16'b0, bits}, (PB == 1) ? 32'b1100100111 : 32'b110010011);

        // Random traffic with occasional resets; the model checker covers every cycle.
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 59) != 0);
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1; tx_valid = 1'b0;
        wait_ready();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
